// File: rtl/line_window_3x3_pkg.sv
// Shared constants for the 3x3 window front end of the Sobel path.
// WIN_LATENCY is the pixel-to-window delay the edge stage aligns to.
package line_window_3x3_pkg;

   localparam int DATA_W       = 24;
   localparam int H_ACTIVE_DEF = 640;
   localparam int ADDR_W_DEF   = 10;
   localparam int WIN_LATENCY  = 2;

   typedef logic [1:0] row_t;
   localparam row_t ROW_FULL = 2'd2;

   // Line counter only needs to know "at least two lines seen".
   function automatic row_t row_inc(input row_t r);
      return (r == ROW_FULL) ? ROW_FULL : r + 2'd1;
   endfunction

endpackage

// File: rtl/line_window_3x3_line_buffer.sv
// One line of pixel storage: synchronous read at ADDR on WE, read-before-write.
// The write is posted: WE/ADDR are captured and WDATA lands one cycle later.
// This lets a cascaded buffer be fed from another buffer's registered read data.
module line_buffer #(
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
) (
   input  logic              CLK,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic [DATA_W-1:0] RDATA
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge CLK) begin
      we_q   <= WE;
      addr_q <= ADDR;
      if (we_q)
         mem[addr_q] <= WDATA;
      if (WE)
         RDATA <= mem[ADDR];
   end

endmodule

// File: rtl/line_window_3x3.sv
// Raster RGB888 stream to 3x3 window: two cascaded line buffers plus a
// 3x3 shift array; one interior window per accepted pixel, 2-cycle latency.
module line_window_3x3 #(
   parameter int H_ACTIVE = line_window_3x3_pkg::H_ACTIVE_DEF,
   parameter int ADDR_W   = line_window_3x3_pkg::ADDR_W_DEF,
   parameter int DATA_W   = line_window_3x3_pkg::DATA_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   input  logic              DIN_SOF,
   output logic [DATA_W-1:0] D00,
   output logic [DATA_W-1:0] D01,
   output logic [DATA_W-1:0] D02,
   output logic [DATA_W-1:0] D10,
   output logic [DATA_W-1:0] D11,
   output logic [DATA_W-1:0] D12,
   output logic [DATA_W-1:0] D20,
   output logic [DATA_W-1:0] D21,
   output logic [DATA_W-1:0] D22,
   output logic              DOUT_VALID,
   output logic              DOUT_SOF
);

   import line_window_3x3_pkg::*;

   typedef struct packed {
      logic [DATA_W-1:0] din;
      logic [ADDR_W-1:0] col;
      row_t              row;
      logic              sof;
   } s1_t;

   localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(H_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] FIRST_WIN = ADDR_W'(2);

   logic [ADDR_W-1:0]            col, cur_col;
   row_t                         row, cur_row;
   logic                         accept;
   s1_t                          s1;
   logic [WIN_LATENCY-1:0]       vld_pipe;
   logic                         interior, sof_pend, sof_hit, dout_sof_q;
   logic [2:0][2:0][DATA_W-1:0]  win;
   logic [DATA_W-1:0]            lb1_q, lb2_q;

   // SOF overrides the counters so a mid-frame restart is clean.
   assign accept  = DIN_VALID & ~RESET;
   assign cur_col = DIN_SOF ? '0 : col;
   assign cur_row = DIN_SOF ? '0 : row;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         col <= '0;
         row <= '0;
      end else if (DIN_VALID) begin
         if (cur_col == LAST_COL) begin
            col <= '0;
            row <= row_inc(cur_row);
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   line_buffer #(.DEPTH(H_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lb1 (
      .CLK   (CLK),
      .WE    (accept),
      .ADDR  (cur_col),
      .WDATA (s1.din),
      .RDATA (lb1_q)
   );

   line_buffer #(.DEPTH(H_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lb2 (
      .CLK   (CLK),
      .WE    (accept),
      .ADDR  (cur_col),
      .WDATA (lb1_q),
      .RDATA (lb2_q)
   );

   always_ff @(posedge CLK) begin
      if (RESET)
         s1 <= '0;
      else if (DIN_VALID)
         s1 <= '{din: DIN, col: cur_col, row: cur_row, sof: DIN_SOF};
   end

   // Stale line-buffer contents are harmless: windows need row >= 2.
   assign interior = (s1.row == ROW_FULL) && (s1.col >= FIRST_WIN);
   assign sof_hit  = s1.sof | sof_pend;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         win        <= '0;
         vld_pipe   <= '0;
         sof_pend   <= 1'b0;
         dout_sof_q <= 1'b0;
      end else begin
         vld_pipe   <= {vld_pipe[0] & interior, DIN_VALID};
         dout_sof_q <= 1'b0;
         if (vld_pipe[0]) begin
            for (int r = 0; r < 3; r++) begin
               win[r][2] <= win[r][1];
               win[r][1] <= win[r][0];
            end
            win[2][0] <= s1.din;
            win[1][0] <= lb1_q;
            win[0][0] <= lb2_q;
            if (interior) begin
               dout_sof_q <= sof_hit;
               sof_pend   <= 1'b0;
            end else begin
               sof_pend   <= sof_hit;
            end
         end
      end
   end

   assign D00 = win[0][0];
   assign D01 = win[0][1];
   assign D02 = win[0][2];
   assign D10 = win[1][0];
   assign D11 = win[1][1];
   assign D12 = win[1][2];
   assign D20 = win[2][0];
   assign D21 = win[2][1];
   assign D22 = win[2][2];

   assign DOUT_VALID = vld_pipe[WIN_LATENCY-1];
   assign DOUT_SOF   = dout_sof_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3: a 4-wide instance for directed frames and a
// 640-wide instance for a random frame, both checked by a window scoreboard.
module tb_line_window_3x3;

   import line_window_3x3_pkg::*;

   localparam int HS = 4;
   localparam int AS = 2;
   localparam int HL = 640;
   localparam int AL = 10;

   typedef logic [8:0][DATA_W-1:0] taps_t;
   typedef struct packed {
      logic [31:0] t;
      logic        sof;
      taps_t       d;
   } win_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] din [2];
   logic              vin [2];
   logic              sin [2];
   logic              vo  [2];
   logic              so  [2];
   taps_t             tp0, tp1;

   int                vectors = 0;
   int                miscompares = 0;
   int                cyc = 0;
   int                wcnt [2];
   logic              first [2];
   logic              prev0 = 1'b0;
   logic              gap_chk = 1'b0;
   win_t              q0 [$];
   win_t              q1 [$];
   win_t              hist0 [$];
   logic [DATA_W-1:0] fm0 [8][HS];
   logic [DATA_W-1:0] fm1 [8][HL];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   line_window_3x3 #(.H_ACTIVE(HS), .ADDR_W(AS), .DATA_W(DATA_W)) u_s (
      .CLK(clk), .RESET(rst), .DIN(din[0]), .DIN_VALID(vin[0]), .DIN_SOF(sin[0]),
      .D00(tp0[0]), .D01(tp0[1]), .D02(tp0[2]),
      .D10(tp0[3]), .D11(tp0[4]), .D12(tp0[5]),
      .D20(tp0[6]), .D21(tp0[7]), .D22(tp0[8]),
      .DOUT_VALID(vo[0]), .DOUT_SOF(so[0])
   );

   line_window_3x3 #(.H_ACTIVE(HL), .ADDR_W(AL), .DATA_W(DATA_W)) u_l (
      .CLK(clk), .RESET(rst), .DIN(din[1]), .DIN_VALID(vin[1]), .DIN_SOF(sin[1]),
      .D00(tp1[0]), .D01(tp1[1]), .D02(tp1[2]),
      .D10(tp1[3]), .D11(tp1[4]), .D12(tp1[5]),
      .D20(tp1[6]), .D21(tp1[7]), .D22(tp1[8]),
      .DOUT_VALID(vo[1]), .DOUT_SOF(so[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard pop: expected windows carry the cycle they must appear in.
   task automatic mon(input int w, input logic v, input logic s, input taps_t t);
      win_t a, e;
      a = '{t: cyc, sof: s, d: t};
      if (w == 0 && gap_chk && v) begin
         vectors++;
         if (prev0) begin
            miscompares++;
            $display("FAIL gap_consecutive: DOUT_VALID high two cycles at cycle %0d", cyc);
         end
      end
      if (w == 0) prev0 = v;
      if (!v) return;
      wcnt[w]++;
      if (w == 0) hist0.push_back(a);
      vectors++;
      if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
         miscompares++;
         $display("FAIL spurious_window%0d: unexpected window %h at cycle %0d", w, a, cyc);
         return;
      end
      e = (w == 0) ? q0.pop_front() : q1.pop_front();
      if (a !== e) begin
         miscompares++;
         $display("FAIL window%0d: got %h, expected %h", w, a, e);
      end
   endtask

   always @(negedge clk) begin
      mon(0, vo[0], so[0], tp0);
      mon(1, vo[1], so[1], tp1);
   end

   task automatic px(input int w, input int r, input int c, input logic [DATA_W-1:0] v,
                     input logic sof, input int gap);
      win_t e;
      if (w == 0) fm0[r][c] = v; else fm1[r][c] = v;
      if (sof) first[w] = 1'b1;
      if (r >= 2 && c >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               if (w == 0) e.d[i*3+j] = fm0[r-2+i][c-j];
               else        e.d[i*3+j] = fm1[r-2+i][c-j];
         e.sof = first[w];
         e.t   = cyc + WIN_LATENCY;
         first[w] = 1'b0;
         if (w == 0) q0.push_back(e); else q1.push_back(e);
      end
      din[w] = v; vin[w] = 1'b1; sin[w] = sof;
      @(posedge clk); #1;
      vin[w] = 1'b0; sin[w] = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic frame(input int w, input int npix, input int base, input int gap,
                        input logic rnd);
      int h;
      h = (w == 0) ? HS : HL;
      for (int k = 0; k < npix; k++) begin
         int r, c;
         r = k / h;
         c = k % h;
         px(w, r, c, rnd ? DATA_W'($urandom) : DATA_W'(base + r*16 + c), k == 0, gap);
      end
   endtask

   task automatic drain(input int w, input string nm);
      int n;
      for (int i = 0; i < 40; i++) begin
         n = (w == 0) ? q0.size() : q1.size();
         if (n == 0) break;
         @(posedge clk); #1;
      end
      repeat (4) begin @(posedge clk); #1; end
      chk(nm, (w == 0) ? q0.size() : q1.size(), 0);
      if (w == 0) q0.delete(); else q1.delete();
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_taps"}, 32'(tp0 != '0), 0);
      chk({nm, "_valid"}, 32'(vo[0]), 0);
      chk({nm, "_sof"}, 32'(so[0]), 0);
   endtask

   task automatic chk_frame_a(input string nm, input int h);
      if (hist0.size() >= h + 4) begin
         chk({nm, "_D00"}, 32'(hist0[h].d[0]), 32'h02);
         chk({nm, "_D01"}, 32'(hist0[h].d[1]), 32'h01);
         chk({nm, "_D02"}, 32'(hist0[h].d[2]), 32'h00);
         chk({nm, "_D10"}, 32'(hist0[h].d[3]), 32'h12);
         chk({nm, "_D20"}, 32'(hist0[h].d[6]), 32'h22);
         chk({nm, "_D22"}, 32'(hist0[h].d[8]), 32'h20);
         chk({nm, "_SOF"}, 32'(hist0[h].sof), 1);
         chk({nm, "_row3_D22"}, 32'(hist0[h+2].d[8]), 32'h30);
         chk({nm, "_last_D20"}, 32'(hist0[h+3].d[6]), 32'h33);
      end
   endtask

   initial begin
      int b, h;
      for (int w = 0; w < 2; w++) begin
         din[w] = '0; vin[w] = 1'b0; sin[w] = 1'b0; wcnt[w] = 0; first[w] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Frame A, continuous valid
      b = wcnt[0]; h = hist0.size();
      frame(0, 16, 0, 0, 1'b0);
      drain(0, "a_drain");
      chk("a_count", wcnt[0] - b, 4);
      chk_frame_a("a", h);

      // Frame A with a bubble after every pixel
      gap_chk = 1'b1;
      b = wcnt[0]; h = hist0.size();
      frame(0, 16, 0, 1, 1'b0);
      drain(0, "gap_drain");
      gap_chk = 1'b0;
      chk("gap_count", wcnt[0] - b, 4);
      chk_frame_a("gap", h);

      // Running frame cut by SOF at pixel (2,1)
      b = wcnt[0]; h = hist0.size();
      frame(0, 9, 'h800, 0, 1'b0);
      frame(0, 16, 'h400, 0, 1'b0);
      drain(0, "sof_drain");
      chk("sof_count", wcnt[0] - b, 4);
      if (hist0.size() > h) chk("sof_first_flag", 32'(hist0[h].sof), 1);

      // Reset in the middle of row 3
      frame(0, 13, 'h600, 0, 1'b0);
      drain(0, "rst_pre_drain");
      rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("mid_reset");
      rst = 1'b0;
      b = wcnt[0]; h = hist0.size();
      frame(0, 16, 0, 0, 1'b0);
      drain(0, "rst_drain");
      chk("rst_count", wcnt[0] - b, 4);
      chk_frame_a("rst", h);

      // Full-width random frame
      b = wcnt[1];
      frame(1, 8*HL, 0, 0, 1'b1);
      drain(1, "big_drain");
      chk("big_count", wcnt[1] - b, (HL-2)*6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
